rsa_modexp_unit: RTL and testbench



---
 rtl/rsa_modexp_unit.sv | 113 +++++++++++
 tb/tb_rsa_modexp_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_unit.sv
// Textbook-RSA modular exponentiation engine: output_data = m^e mod n.
// Controller FSM plus multiply / combinational-remainder datapath behind a single
// command port. The exponent and modulus are loadable and default to (17, 3233).
module rsa_modexp_unit #(
  parameter int unsigned DW    = 13,
  parameter int unsigned OW    = 16,
  parameter int unsigned E_RST = 17,
  parameter int unsigned N_RST = 3233
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data,
  input  logic [2:0]    input_data_type,
  output logic [OW-1:0] output_data,
  output logic          done
);

  typedef enum logic [2:0] {StIdle, StInit, StMult, StMod, StDone} state_e;

  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdLoadE = 3'd2;
  localparam logic [2:0] CmdLoadN = 3'd3;
  localparam logic [DW:0] CountOne = 1;

  state_e        state_q;
  logic [DW-1:0] e_q;
  logic [DW-1:0] n_q;
  logic [DW-1:0] m_q;
  logic [DW-1:0] acc_q;
  logic [31:0]   prod_q;
  logic [DW:0]   count_q;

  logic [DW-1:0] init_rem;
  logic [DW-1:0] mod_rem;
  logic [DW:0]   count_inc;

  // Remainder that treats a zero modulus as yielding 0 instead of dividing by zero.
  function automatic logic [DW-1:0] mod_n(input logic [31:0] x, input logic [DW-1:0] d);
    logic [31:0] r;
    if (d == '0) begin
      r = '0;
    end else begin
      r = x % 32'(d);
    end
    return r[DW-1:0];
  endfunction

  // Datapath: first accumulator value (e=0 means the empty product, 1 mod n),
  // per-step remainder of the registered product, and the advanced step count.
  always_comb begin
    init_rem  = (e_q == '0) ? mod_n(32'd1, n_q) : mod_n(32'(m_q), n_q);
    mod_rem   = mod_n(prod_q, n_q);
    count_inc = count_q + CountOne;
  end

  // Controller FSM with all state, key registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      e_q         <= DW'(E_RST);
      n_q         <= DW'(N_RST);
      m_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      count_q     <= '0;
      output_data <= '0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          case (input_data_type)
            CmdStart: begin
              m_q     <= data;
              done    <= 1'b0;
              count_q <= CountOne;
              state_q <= StInit;
            end
            CmdLoadE: e_q <= data;
            CmdLoadN: n_q <= data;
            default: ;
          endcase
        end
        StInit: begin
          acc_q <= init_rem;
          if (count_q >= {1'b0, e_q}) begin
            output_data <= OW'(init_rem);
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            state_q <= StMult;
          end
        end
        StMult: begin
          prod_q  <= 32'(acc_q) * 32'(m_q);
          state_q <= StMod;
        end
        StMod: begin
          acc_q   <= mod_rem;
          count_q <= count_inc;
          if (count_inc >= {1'b0, e_q}) begin
            output_data <= OW'(mod_rem);
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            state_q <= StMult;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed self-checking bench for rsa_modexp_unit.
module tb_rsa_modexp_unit;

  logic        clk;
  logic        rst;
  logic [12:0] data;
  logic [2:0]  input_data_type;
  logic [15:0] output_data;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  rsa_modexp_unit dut (
    .clk             (clk),
    .rst             (rst),
    .data            (data),
    .input_data_type (input_data_type),
    .output_data     (output_data),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Square-and-multiply reference for m^e mod n (n=0 gives 0).
  function automatic int unsigned model(input int unsigned m, input int unsigned e,
                                        input int unsigned n);
    longint unsigned r, b;
    int unsigned     k;
    if (n == 0) return 0;
    r = 64'd1 % n;
    b = m % n;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * b) % n;
      b = (b * b) % n;
      k = k >> 1;
    end
    return int'(r);
  endfunction

  // Hold a command for exactly one rising edge, ending on a falling edge.
  task automatic send_cmd(input logic [2:0] t, input logic [12:0] d);
    @(negedge clk);
    input_data_type = t;
    data            = d;
    @(negedge clk);
    input_data_type = 3'd0;
    data            = '0;
  endtask

  // Issue a start; returns just after the sampling edge k.
  task automatic start_cmd(input logic [12:0] m);
    @(negedge clk);
    input_data_type = 3'd1;
    data            = m;
    @(posedge clk);
    #1;
    input_data_type = 3'd0;
    data            = '0;
  endtask

  // Counts edges after edge k until done; bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("done_within_bound", done, 1);
  endtask

  task automatic run(input logic [12:0] m, output int unsigned res, output int cycles);
    start_cmd(m);
    wait_done(cycles);
    res = output_data;
  endtask

  int unsigned res;
  int          cyc;

  initial begin
    rst             = 1'b1;
    data            = '0;
    input_data_type = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_done", done, 0);
    check("reset_output", output_data, 0);
    rst = 1'b0;

    // Default key (17, 3233)
    run(13'd2, res, cyc);
    check("m2_result", res, 1752);
    check("m2_latency", cyc, 33);
    run(13'd65, res, cyc);
    check("m65_result", res, 2790);
    run(13'd0, res, cyc);
    check("m0_result", res, 0);
    run(13'd1, res, cyc);
    check("m1_result", res, 1);

    // Result and done hold while idle in DONE
    repeat (5) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_output", output_data, 1);

    for (int m = 0; m < 256; m++) begin
      run(13'(m), res, cyc);
      check($sformatf("sweep17_m%0d", m), res, model(m, 17, 3233));
    end

    // Key loads while busy are ignored; output holds its old value mid-run
    run(13'd2, res, cyc);
    start_cmd(13'd3);
    check("busy_done_cleared", done, 0);
    send_cmd(3'd2, 13'd5);
    send_cmd(3'd3, 13'd77);
    check("busy_output_held", output_data, 1752);
    wait_done(cyc);
    check("busy_result", output_data, model(3, 17, 3233));
    run(13'd2, res, cyc);
    check("busy_key_kept", res, 1752);
    check("busy_key_latency", cyc, 33);

    // Key loads in DONE do not disturb done/output_data
    send_cmd(3'd2, 13'd3);
    check("load_e_done", done, 1);
    send_cmd(3'd3, 13'd15);
    check("load_n_output", output_data, 1752);
    // Unused command codes are ignored
    send_cmd(3'd5, 13'd9);
    check("cmd5_ignored", output_data, 1752);
    run(13'd7, res, cyc);
    check("e3n15_m7", res, 13);
    check("e3_latency", cyc, 5);
    for (int m = 0; m < 15; m++) begin
      run(13'(m), res, cyc);
      check($sformatf("sweep3_m%0d", m), res, model(m, 3, 15));
    end

    // Edge cases
    send_cmd(3'd2, 13'd0);
    run(13'd7, res, cyc);
    check("e0_result", res, 1);
    check("e0_latency", cyc, 1);
    send_cmd(3'd2, 13'd1);
    run(13'd22, res, cyc);
    check("e1_result", res, 7);
    check("e1_latency", cyc, 1);
    send_cmd(3'd2, 13'd3);
    send_cmd(3'd3, 13'd1);
    run(13'd9, res, cyc);
    check("n1_result", res, 0);
    send_cmd(3'd3, 13'd0);
    run(13'd9, res, cyc);
    check("n0_result", res, 0);
    send_cmd(3'd2, 13'd0);
    run(13'd9, res, cyc);
    check("e0n0_result", res, 0);

    // Reset mid-computation restores defaults
    send_cmd(3'd2, 13'd4000);
    send_cmd(3'd3, 13'd101);
    start_cmd(13'd5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_done", done, 0);
    check("midrst_output", output_data, 0);
    @(negedge clk);
    rst = 1'b0;
    run(13'd2, res, cyc);
    check("post_rst_result", res, 1752);
    check("post_rst_latency", cyc, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
